// File: rtl/adder_operand_loader_pkg.sv
// Shared definitions for the adder operand loader: FSM state encoding and default sizing.
package adder_operand_loader_pkg;

    // Encodings are driven straight onto the board LEDs, so the values are fixed.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_GOT_A = 2'b01,
        S_GOT_B = 2'b10,
        S_RUN   = 2'b11
    } state_t;

    localparam int unsigned OPW_DEFAULT       = 2;
    localparam int unsigned DB_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/adder_operand_loader_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, accepted level and rising-edge pulse.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;
    logic          stable;
    logic          stable_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // cnt only advances while s2 disagrees and is cleared on acceptance, so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            stable_q <= stable;
            if (s2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign pulse = stable & ~stable_q;

endmodule

// File: rtl/adder_operand_loader.sv
// Captures operand A, operand B and carry-in from board switches, one field per LOAD press.
module adder_operand_loader
    import adder_operand_loader_pkg::*;
#(
    parameter int unsigned OPW       = OPW_DEFAULT,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] sw,
    input  logic           sw_ci,
    input  logic           btn_load,
    input  logic           btn_clear,
    output logic [OPW-1:0] a_out,
    output logic [OPW-1:0] b_out,
    output logic           ci_out,
    output logic           op_valid,
    output logic [1:0]     state_led
);

    logic [OPW-1:0] sw_m;
    logic [OPW-1:0] sw_s;
    logic           ci_m;
    logic           ci_s;
    logic           load_pulse;
    logic           clear_pulse;

    state_t         state;
    state_t         state_nxt;
    logic [OPW-1:0] a_nxt;
    logic [OPW-1:0] b_nxt;
    logic           ci_nxt;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_load_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_load),
        .pulse   (load_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .pulse   (clear_pulse)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            sw_m <= '0;
            sw_s <= '0;
            ci_m <= 1'b0;
            ci_s <= 1'b0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
            ci_m <= sw_ci;
            ci_s <= ci_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            a_out    <= '0;
            b_out    <= '0;
            ci_out   <= 1'b0;
            op_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_out    <= a_nxt;
            b_out    <= b_nxt;
            ci_out   <= ci_nxt;
            op_valid <= (state_nxt == S_RUN);
        end
    end

    // Clear has priority; a coincident load pulse is simply dropped.
    always_comb begin
        state_nxt = state;
        a_nxt     = a_out;
        b_nxt     = b_out;
        ci_nxt    = ci_out;
        if (clear_pulse) begin
            state_nxt = S_IDLE;
            a_nxt     = '0;
            b_nxt     = '0;
            ci_nxt    = 1'b0;
        end else if (load_pulse) begin
            case (state)
                S_IDLE: begin
                    a_nxt     = sw_s;
                    state_nxt = S_GOT_A;
                end
                S_GOT_A: begin
                    b_nxt     = sw_s;
                    state_nxt = S_GOT_B;
                end
                S_GOT_B: begin
                    ci_nxt    = ci_s;
                    state_nxt = S_RUN;
                end
                S_RUN: begin
                    a_nxt     = sw_s;
                    b_nxt     = '0;
                    ci_nxt    = 1'b0;
                    state_nxt = S_GOT_A;
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    assign state_led = state;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader with a run-length debounce model and per-cycle compare.
module tb_adder_operand_loader;

    localparam int unsigned OPW = 2;
    localparam int unsigned DB  = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [OPW-1:0] sw = '0;
    logic           sw_ci = 1'b0;
    logic           btn_load = 1'b0;
    logic           btn_clear = 1'b0;
    logic [OPW-1:0] a_out;
    logic [OPW-1:0] b_out;
    logic           ci_out;
    logic           op_valid;
    logic [1:0]     state_led;

    adder_operand_loader #(.OPW(OPW), .DB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .sw_ci     (sw_ci),
        .btn_load  (btn_load),
        .btn_clear (btn_clear),
        .a_out     (a_out),
        .b_out     (b_out),
        .ci_out    (ci_out),
        .op_valid  (op_valid),
        .state_led (state_led)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: a button level is accepted once DB consecutive raw samples differ from the
    // accepted level; the resulting action lands 3 edges after the last such sample, using
    // the switch value sampled 2 edges before the action.
    int unsigned    run_ld, run_cl;
    logic           acc_ld, acc_cl;
    logic [2:0]     pend_ld, pend_cl;
    logic [OPW-1:0] swh1, swh0;
    logic           cih1, cih0;
    int unsigned    fields;
    logic [OPW-1:0] m_a, m_b;
    logic           m_ci;
    logic           model_live = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            run_ld <= 0; run_cl <= 0; acc_ld <= 1'b0; acc_cl <= 1'b0;
            pend_ld <= '0; pend_cl <= '0;
            swh1 <= '0; swh0 <= '0; cih1 <= 1'b0; cih0 <= 1'b0;
            fields <= 0; m_a <= '0; m_b <= '0; m_ci <= 1'b0;
            model_live <= 1'b1;
        end else begin
            swh1 <= sw; swh0 <= swh1; cih1 <= sw_ci; cih0 <= cih1;

            if (btn_load != acc_ld) begin
                if (run_ld + 1 == DB) begin acc_ld <= btn_load; run_ld <= 0; end
                else run_ld <= run_ld + 1;
            end else run_ld <= 0;
            pend_ld <= {(btn_load && !acc_ld && (run_ld + 1 == DB)), pend_ld[2:1]};

            if (btn_clear != acc_cl) begin
                if (run_cl + 1 == DB) begin acc_cl <= btn_clear; run_cl <= 0; end
                else run_cl <= run_cl + 1;
            end else run_cl <= 0;
            pend_cl <= {(btn_clear && !acc_cl && (run_cl + 1 == DB)), pend_cl[2:1]};

            if (pend_cl[0]) begin
                fields <= 0; m_a <= '0; m_b <= '0; m_ci <= 1'b0;
            end else if (pend_ld[0]) begin
                if (fields == 0) begin m_a <= swh0; fields <= 1; end
                else if (fields == 1) begin m_b <= swh0; fields <= 2; end
                else if (fields == 2) begin m_ci <= cih0; fields <= 3; end
                else begin m_a <= swh0; m_b <= '0; m_ci <= 1'b0; fields <= 1; end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (model_live) begin
            check("model a_out", 8'(a_out), 8'(m_a));
            check("model b_out", 8'(b_out), 8'(m_b));
            check("model ci_out", 8'(ci_out), 8'(m_ci));
            check("model op_valid", 8'(op_valid), 8'(fields == 3));
            check("model state_led", 8'(state_led), 8'(fields));
        end
    end

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic ld, input logic cl, input int unsigned hold);
        @(negedge clk);
        btn_load  = ld;
        btn_clear = cl;
        idle(hold);
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        idle(12);
    endtask

    task automatic check_all(input string tag, input logic [1:0] a, input logic [1:0] b,
                             input logic ci, input logic ov, input logic [1:0] st);
        check({tag, " a_out"}, 8'(a_out), 8'(a));
        check({tag, " b_out"}, 8'(b_out), 8'(b));
        check({tag, " ci_out"}, 8'(ci_out), 8'(ci));
        check({tag, " op_valid"}, 8'(op_valid), 8'(ov));
        check({tag, " state_led"}, 8'(state_led), 8'(st));
    endtask

    initial begin
        // 1: reset and quiet idle
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        check_all("reset", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
        idle(20);
        check_all("idle", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);

        // 2: load A with edge-exact latency, then B and carry-in
        sw = 2'b10;
        idle(3);
        @(negedge clk) btn_load = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("latency edge6 state", 8'(state_led), 8'h0);
        @(posedge clk);
        #1 check("latency edge7 a_out", 8'(a_out), 8'h2);
        check("latency edge7 state", 8'(state_led), 8'h1);
        idle(4);
        btn_load = 1'b0;
        idle(12);
        sw = 2'b01;
        idle(3);
        press(1'b1, 1'b0, 8);
        check_all("load B", 2'b10, 2'b01, 1'b0, 1'b0, 2'b10);
        sw_ci = 1'b1;
        idle(3);
        press(1'b1, 1'b0, 8);
        check_all("load ci", 2'b10, 2'b01, 1'b1, 1'b1, 2'b11);

        // 4: load from RUN starts a new set
        sw = 2'b11;
        idle(3);
        press(1'b1, 1'b0, 8);
        check_all("run reload", 2'b11, 2'b00, 1'b0, 1'b0, 2'b01);

        // 3: bouncy press loads exactly one field; a 3-cycle pulse loads nothing
        sw = 2'b10;
        idle(3);
        @(negedge clk) btn_load = 1'b1;
        @(negedge clk) btn_load = 1'b0;
        @(negedge clk) btn_load = 1'b1;
        idle(10);
        btn_load = 1'b0;
        idle(12);
        check_all("bounce", 2'b11, 2'b10, 1'b0, 1'b0, 2'b10);
        press(1'b1, 1'b0, 3);
        check_all("short glitch", 2'b11, 2'b10, 1'b0, 1'b0, 2'b10);

        // 5: simultaneous load and clear in GOT_B
        press(1'b1, 1'b1, 8);
        check_all("clear wins", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);

        // 6: reset mid-debounce with LOAD held through deassertion
        sw = 2'b01;
        idle(3);
        press(1'b1, 1'b0, 8);
        check_all("pre-rst load", 2'b01, 2'b00, 1'b0, 1'b0, 2'b01);
        sw = 2'b10;
        idle(3);
        @(negedge clk) btn_load = 1'b1;
        idle(4);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        check_all("mid rst", 2'b00, 2'b00, 1'b0, 1'b0, 2'b00);
        repeat (6) @(posedge clk);
        #1 check("post-rst edge6 state", 8'(state_led), 8'h0);
        @(posedge clk);
        #1 check("post-rst edge7 a_out", 8'(a_out), 8'h2);
        check("post-rst edge7 state", 8'(state_led), 8'h1);
        idle(4);
        btn_load = 1'b0;
        idle(12);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
